// File: rtl/seq_tx_1011.sv
// Bit-serial frame transmitter: sends preamble 1,0,1,1, then the payload MSB-first,
// then GAP zero bit periods. Frame position advances only on bit_en strobes.
module seq_tx_1011 #(
  parameter int DATA_W = 8,
  parameter int GAP    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bit_en,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_bit,
  output logic              out_valid,
  output logic              frame_start,
  output logic              frame_done,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2,
    GAPS = 2'd3
  } state_t;

  // Index 0 is the first preamble bit on the line.
  localparam logic [3:0] PREAMBLE  = 4'b1101;
  localparam logic [5:0] LAST_DATA = 6'(DATA_W - 1);
  localparam logic [5:0] LAST_GAP  = 6'((GAP > 0) ? GAP - 1 : 0);

  state_t              state_q, state_d;
  logic [5:0]          idx_q, idx_d;
  logic [DATA_W-1:0]   sh_q, sh_d;
  logic                out_bit_q, out_bit_d;
  logic                out_valid_q, out_valid_d;
  logic                frame_start_q, frame_start_d;
  logic                frame_done_q, frame_done_d;
  logic                busy_q, busy_d;

  always_comb begin
    // NOTE: every _d gets a default first so no path through the case infers a latch.
    state_d       = state_q;
    idx_d         = idx_q;
    sh_d          = sh_q;
    out_bit_d     = out_bit_q;
    out_valid_d   = out_valid_q;
    frame_start_d = frame_start_q;
    frame_done_d  = 1'b0;
    busy_d        = busy_q;

    case (state_q)
      IDLE: begin
        // Acceptance ignores bit_en; the first preamble bit appears next cycle.
        if (in_valid) begin
          state_d       = PRE;
          idx_d         = '0;
          sh_d          = in_data;
          out_bit_d     = PREAMBLE[0];
          out_valid_d   = 1'b1;
          frame_start_d = 1'b1;
          busy_d        = 1'b1;
        end
      end
      PRE: begin
        if (bit_en) begin
          frame_start_d = 1'b0;
          if (idx_q == 6'd3) begin
            state_d   = DATA;
            idx_d     = '0;
            out_bit_d = sh_q[DATA_W-1];
          end else begin
            idx_d     = idx_q + 6'd1;
            out_bit_d = PREAMBLE[idx_q[1:0] + 2'd1];
          end
        end
      end
      DATA: begin
        if (bit_en) begin
          if (idx_q == LAST_DATA) begin
            idx_d        = '0;
            out_bit_d    = 1'b0;
            out_valid_d  = 1'b0;
            frame_done_d = 1'b1;
            if (GAP == 0) begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end else begin
              state_d = GAPS;
            end
          end else begin
            idx_d     = idx_q + 6'd1;
            sh_d      = sh_q << 1;
            out_bit_d = sh_d[DATA_W-1];
          end
        end
      end
      GAPS: begin
        if (bit_en) begin
          if (idx_q == LAST_GAP) begin
            state_d = IDLE;
            idx_d   = '0;
            busy_d  = 1'b0;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the shift register is plain flops, not a memory, so it is cleared with the rest.
      state_q       <= IDLE;
      idx_q         <= '0;
      sh_q          <= '0;
      out_bit_q     <= 1'b0;
      out_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      sh_q          <= sh_d;
      out_bit_q     <= out_bit_d;
      out_valid_q   <= out_valid_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      busy_q        <= busy_d;
    end
  end

  assign in_ready    = (state_q == IDLE) && !reset;
  assign out_bit     = out_bit_q;
  assign out_valid   = out_valid_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_seq_tx_1011.sv
// Directed bench for seq_tx_1011: expected line bits are queued when a payload is
// offered and popped as the DUT consumes them on bit_en edges.
module tb_seq_tx_1011;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // u0: DATA_W=8 GAP=2
  logic       bit_en0, in_valid0;
  logic [7:0] in_data0;
  logic       in_ready0, out_bit0, out_valid0, frame_start0, frame_done0, busy0;
  // u1: DATA_W=8 GAP=0
  logic       bit_en1, in_valid1;
  logic [7:0] in_data1;
  logic       in_ready1, out_bit1, out_valid1, frame_start1, frame_done1, busy1;
  // u2: DATA_W=1 GAP=2
  logic       bit_en2, in_valid2;
  logic [0:0] in_data2;
  logic       in_ready2, out_bit2, out_valid2, frame_start2, frame_done2, busy2;

  seq_tx_1011 #(.DATA_W(8), .GAP(2)) u0 (
    .clk(clk), .reset(reset), .bit_en(bit_en0), .in_valid(in_valid0), .in_data(in_data0),
    .in_ready(in_ready0), .out_bit(out_bit0), .out_valid(out_valid0),
    .frame_start(frame_start0), .frame_done(frame_done0), .busy(busy0));

  seq_tx_1011 #(.DATA_W(8), .GAP(0)) u1 (
    .clk(clk), .reset(reset), .bit_en(bit_en1), .in_valid(in_valid1), .in_data(in_data1),
    .in_ready(in_ready1), .out_bit(out_bit1), .out_valid(out_valid1),
    .frame_start(frame_start1), .frame_done(frame_done1), .busy(busy1));

  seq_tx_1011 #(.DATA_W(1), .GAP(2)) u2 (
    .clk(clk), .reset(reset), .bit_en(bit_en2), .in_valid(in_valid2), .in_data(in_data2),
    .in_ready(in_ready2), .out_bit(out_bit2), .out_valid(out_valid2),
    .frame_start(frame_start2), .frame_done(frame_done2), .busy(busy2));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Offers d to u0 from IDLE, strobes bit_en every `period` cycles, checks the frame and gap.
  task automatic run_frame0(input logic [7:0] d, input int period, input bit hold,
                            input logic [7:0] next_d);
    logic q[$];
    int   ph, sent, strobes, gc;
    q.push_back(1'b1); q.push_back(1'b0); q.push_back(1'b1); q.push_back(1'b1);
    for (int i = 7; i >= 0; i--) q.push_back(d[i]);
    check("accept_ready", in_ready0, 1'b1);
    in_valid0 = 1'b1;
    in_data0  = d;
    bit_en0   = (period == 1);
    cyc();
    in_valid0 = hold;
    in_data0  = hold ? next_d : 8'hFF;
    ph   = 0;
    sent = 0;
    while (q.size() > 0) begin
      check("frame_valid", out_valid0, 1'b1);
      check("frame_bit", out_bit0, q[0]);
      check("frame_start", frame_start0, sent == 0);
      check("frame_ready", in_ready0, 1'b0);
      check("frame_busy", busy0, 1'b1);
      check("frame_done_early", frame_done0, 1'b0);
      ph++;
      bit_en0 = (ph % period) == 0;
      if (bit_en0) begin
        void'(q.pop_front());
        sent++;
      end
      cyc();
    end
    strobes = 0;
    gc      = 0;
    while (strobes < 2) begin
      check("gap_done_pulse", frame_done0, gc == 0);
      check("gap_valid", out_valid0, 1'b0);
      check("gap_bit", out_bit0, 1'b0);
      check("gap_ready", in_ready0, 1'b0);
      check("gap_busy", busy0, 1'b1);
      ph++;
      bit_en0 = (ph % period) == 0;
      if (bit_en0) strobes++;
      gc++;
      cyc();
    end
    check("idle_ready", in_ready0, 1'b1);
    check("idle_busy", busy0, 1'b0);
    check("idle_valid", out_valid0, 1'b0);
    check("idle_done", frame_done0, 1'b0);
  endtask

  initial begin
    logic q[$];
    logic [7:0] d1;
    reset     = 1'b1;
    bit_en0   = 1'b0; in_valid0 = 1'b0; in_data0 = '0;
    bit_en1   = 1'b0; in_valid1 = 1'b0; in_data1 = '0;
    bit_en2   = 1'b0; in_valid2 = 1'b0; in_data2 = '0;
    #1;
    check("rst_valid", out_valid0, 1'b0);
    check("rst_bit", out_bit0, 1'b0);
    check("rst_busy", busy0, 1'b0);
    check("rst_start", frame_start0, 1'b0);
    check("rst_done", frame_done0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rel_ready", in_ready0, 1'b1);

    run_frame0(8'hA5, 1, 1'b0, 8'h00);
    run_frame0(8'hA5, 3, 1'b0, 8'h00);
    run_frame0(8'hA5, 1, 1'b1, 8'h3C);
    run_frame0(8'h3C, 1, 1'b0, 8'h00);

    // Abort mid-payload with an asynchronous reset, then hold in_valid during reset.
    in_valid0 = 1'b1;
    in_data0  = 8'hC3;
    bit_en0   = 1'b1;
    cyc();
    in_valid0 = 1'b0;
    repeat (10) cyc();
    check("abort_pre_valid", out_valid0, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("abort_valid", out_valid0, 1'b0);
    check("abort_bit", out_bit0, 1'b0);
    check("abort_busy", busy0, 1'b0);
    check("abort_done", frame_done0, 1'b0);
    in_valid0 = 1'b1;
    in_data0  = 8'h77;
    cyc();
    check("rst_win_busy", busy0, 1'b0);
    check("rst_win_valid", out_valid0, 1'b0);
    in_valid0 = 1'b0;
    reset     = 1'b0;
    cyc();
    check("post_abort_done", frame_done0, 1'b0);
    check("post_abort_ready", in_ready0, 1'b1);
    run_frame0(8'h5A, 1, 1'b0, 8'h00);

    // GAP=0: back-to-back frames with one IDLE cycle; second payload 0x0B sent verbatim.
    in_valid1 = 1'b1;
    in_data1  = 8'h96;
    bit_en1   = 1'b1;
    cyc();
    in_data1 = 8'h0B;
    for (int f = 0; f < 2; f++) begin
      d1 = (f == 0) ? 8'h96 : 8'h0B;
      q.push_back(1'b1); q.push_back(1'b0); q.push_back(1'b1); q.push_back(1'b1);
      for (int i = 7; i >= 0; i--) q.push_back(d1[i]);
      while (q.size() > 0) begin
        check("g0_valid", out_valid1, 1'b1);
        check("g0_bit", out_bit1, q.pop_front());
        check("g0_ready", in_ready1, 1'b0);
        cyc();
      end
      check("g0_idle_valid", out_valid1, 1'b0);
      check("g0_idle_done", frame_done1, 1'b1);
      check("g0_idle_ready", in_ready1, 1'b1);
      if (f == 1) in_valid1 = 1'b0;
      cyc();
    end
    check("g0_end_valid", out_valid1, 1'b0);
    check("g0_end_busy", busy1, 1'b0);
    check("g0_end_done", frame_done1, 1'b0);

    // DATA_W=1 with payload 1.
    in_valid2 = 1'b1;
    in_data2  = 1'b1;
    bit_en2   = 1'b1;
    cyc();
    in_valid2 = 1'b0;
    q.push_back(1'b1); q.push_back(1'b0); q.push_back(1'b1); q.push_back(1'b1);
    q.push_back(1'b1);
    while (q.size() > 0) begin
      check("w1_valid", out_valid2, 1'b1);
      check("w1_bit", out_bit2, q.pop_front());
      cyc();
    end
    check("w1_done", frame_done2, 1'b1);
    check("w1_gap_valid", out_valid2, 1'b0);
    check("w1_gap_ready", in_ready2, 1'b0);
    cyc();
    cyc();
    check("w1_idle_ready", in_ready2, 1'b1);
    check("w1_idle_busy", busy2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_tx_1011.md
Name: seq_tx_1011

Overview:
Bit-serial frame transmitter, the transmit end of the 1011-preamble serial link. Accepts a parallel payload word through a valid/ready handshake and emits one frame on a single-bit line: the fixed preamble 1,0,1,1, then the payload MSB-first, then an inter-frame gap of zeros. Bit pacing comes from a bit-enable strobe so the block can run below the clock rate.

Parameters:
DATA_W, 8, payload width in bits (legal 1..32).
GAP, 2, gap length in bit periods after each frame, with out_bit=0 (legal 0..15).

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
bit_en  input  1  bit-period strobe; the frame position advances only on edges where bit_en=1.
in_valid  input  1  payload offered.
in_data  input  DATA_W  payload word; sampled only on acceptance.
in_ready  output  1  block can accept a payload; high only in IDLE.
out_bit  output  1  serial line.
out_valid  output  1  high while a preamble or payload bit is on out_bit.
frame_start  output  1  high during the first preamble bit period.
frame_done  output  1  one-cycle pulse after the last payload bit is consumed.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, immediate, no clock needed): state=IDLE, shift register and counters cleared, out_bit=0, out_valid=0, frame_start=0, frame_done=0, busy=0. in_ready=1 once reset is released.
- States: IDLE, PRE, DATA, GAP.
- IDLE: in_ready=1, out_bit=0, out_valid=0. Acceptance happens on an edge with in_valid=1 and in_ready=1, regardless of bit_en. On acceptance: latch in_data into the shift register, go to PRE, set bit index 0. in_data changes after acceptance have no effect.
- PRE: out_valid=1. out_bit = preamble[idx] for idx 0..3, with values 1,0,1,1. frame_start=1 while idx=0. Each edge with bit_en=1 advances idx. The edge that consumes idx=3 goes to DATA.
- DATA: out_valid=1. out_bit = current MSB of the shift register. Each edge with bit_en=1 shifts left by one. The edge that consumes the DATA_W-th bit goes to GAP, or to IDLE if GAP=0, and sets frame_done=1 for exactly the next cycle.
- GAP: out_valid=0, out_bit=0, in_ready=0. The state lasts GAP bit_en-qualified edges, then goes to IDLE.
- bit_en=0: hold the state, the index, and out_bit. A bit stays on the line from the cycle it appears until the cycle after the edge that consumes it.
- Latency: the first preamble bit appears in the cycle after the acceptance edge.
- Frame length: 4+DATA_W bit periods.
- Minimum accept-to-accept period with bit_en tied 1: 4+DATA_W+GAP+1 cycles.
- in_ready is low for the whole frame and gap. No back-to-back acceptance during the last bit.
- out_bit, out_valid, frame_start, frame_done and busy are registered outputs, so they are glitch-free.
- Payload is sent verbatim. No bit-stuffing is done, even when the payload contains 1011.
- Reset asserted mid-frame aborts the frame. No frame_done pulse is produced for it.
- Simultaneous in_valid and reset: reset wins, nothing is accepted.

Test Plan:
1. DATA_W=8, GAP=2, bit_en=1, reset then send 0xA5 -> out_valid high for cycles 1..12 with out_bit 1,0,1,1,1,0,1,0,0,1,0,1; frame_start high in cycle 1 only; frame_done high in cycle 13 only; cycles 13-14 out_valid=0; in_ready=1 again from cycle 15.
2. Same setup with bit_en high every 3rd cycle -> identical 12-bit sequence, each bit held exactly 3 cycles; gap lasts 2 strobes; busy high throughout.
3. in_valid held high with in_data changed to 0x3C during the frame -> first frame carries 0xA5; second frame (0x3C) accepted on the first IDLE cycle; its preamble starts the cycle after.
4. Assert reset asynchronously (between clock edges) after 6 bits of the payload -> out_valid, out_bit and busy drop to 0 without waiting for an edge; no frame_done; the next accepted frame starts with the full preamble.
5. GAP=0 instance, in_valid held high -> frames separated by exactly one IDLE cycle (out_valid=0); frame_done coincides with that IDLE cycle.
6. Payload 0x0B -> 1,0,1,1,0,0,0,0,1,0,1,1 transmitted verbatim (no stuffing); DATA_W=1 with payload 1 -> 1,0,1,1,1.
